// File: rtl/seg7_pkg.sv
// seg7_pkg: constants and types shared by the 7-segment display encoder and
// the scan-capture reader.
//   SEG_W / BCD_W      : segment bus and BCD digit widths
//   SEG_0 .. SEG_9     : active-low segment patterns, segments a..g on bits 6..0
//   BCD_INVALID        : value reported for a pattern that is not a legal digit
//   scan_state_e       : capture FSM states
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int BCD_W = 4;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0000100;

  localparam logic [BCD_W-1:0] BCD_INVALID = 4'hF;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_scan_capture_decode.sv
// seg7_decode: combinational active-low segment pattern to BCD decoder.
//   seg_n : segments a..g on bits 6..0, 0 = lit
//   bcd   : decoded digit, BCD_INVALID for any non-digit pattern
//   err   : set when seg_n is not one of the ten legal patterns
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg_n,
  output logic [BCD_W-1:0] bcd,
  output logic             err
);

  always_comb begin
    bcd = BCD_INVALID;
    err = 1'b0;
    case (seg_n)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: begin
        bcd = BCD_INVALID;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: reader for a multiplexed, active-low 7-segment display.
// Samples the anode and segment buses, waits for each digit to be shown
// stably, decodes it back to BCD and assembles complete frames.
//   clk, rst_n   : clock, asynchronous active-low reset
//   an_n         : anode enables, bit i low = digit i displayed
//   seg_n        : segments a..g on bits 6..0, active-low
//   digits       : captured BCD values, digit i at [4i+3:4i]
//   digit_err    : bit i set when the last capture of digit i was illegal
//   frame_valid  : one-cycle pulse once every digit has been captured
//   frame_err    : OR of digit_err over the completed frame (with frame_valid)
//   multi_drive  : high for every sampled cycle with two or more anodes low
//   dbg_state    : current capture FSM state
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS    = 4,
  parameter  int STABLE_CYCLES = 8,
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [SEG_W-1:0]        seg_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    multi_drive,
  output scan_state_e             dbg_state
);

  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(STABLE_CYCLES);

  logic [NUM_DIGITS-1:0] an_q;
  logic [SEG_W-1:0]      seg_q;
  logic [NUM_DIGITS-1:0] seen;
  logic [CNT_W-1:0]      cnt, cnt_d;
  scan_state_e           state, state_d;
  logic                  capture;

  logic [NUM_DIGITS-1:0] low_in, low_q;
  logic                  onehot_in;
  logic                  same;
  logic [BCD_W-1:0]      dec_bcd;
  logic                  dec_err;
  logic                  frame_done;
  logic [NUM_DIGITS-1:0] cap_mask;
  logic [NUM_DIGITS-1:0] seen_d;

  seg7_decode u_decode (
    .seg_n (seg_q),
    .bcd   (dec_bcd),
    .err   (dec_err)
  );

  // The state and counter describe the word being registered on this edge:
  // the counter equals the number of consecutive identical samples ending
  // with that word, so the incoming word is compared against the one already
  // held in an_q/seg_q. This makes the capture land on the same edge that
  // registers the STABLE_CYCLES-th identical sample.
  assign low_in    = ~an_n;
  assign low_q     = ~an_q;
  assign onehot_in = (low_in != '0) && ((low_in & (low_in - AN_ONE)) == '0);
  assign same      = ({an_n, seg_n} == {an_q, seg_q});

  assign multi_drive = ((low_q & (low_q - AN_ONE)) != '0);
  assign dbg_state   = state;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    capture = 1'b0;
    case (state)
      BLANK: begin
        if (onehot_in) begin
          state_d = SETTLE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (!onehot_in) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else if (!same) begin
          cnt_d   = CNT_ONE;
        end else if (cnt >= CNT_LAST) begin
          capture = 1'b1;
          state_d = HELD;
          cnt_d   = CNT_MAX;
        end else begin
          cnt_d   = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!same) begin
          if (onehot_in) begin
            state_d = SETTLE;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = BLANK;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Capture only happens with an_q equal to the one-hot-low incoming word,
  // so its inversion is directly the write mask.
  assign cap_mask   = capture ? low_q : '0;
  assign frame_done = &seen;
  // The frame clear is applied before this edge's capture so that capture
  // counts toward the next frame.
  assign seen_d     = (frame_done ? '0 : seen) | cap_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q        <= '1;
      seg_q       <= '1;
      state       <= BLANK;
      cnt         <= '0;
      seen        <= '0;
      digits      <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      an_q        <= an_n;
      seg_q       <= seg_n;
      state       <= state_d;
      cnt         <= cnt_d;
      seen        <= seen_d;
      frame_valid <= frame_done;
      frame_err   <= frame_done & (|digit_err);
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_mask[i]) begin
          digits[4*i +: 4] <= dec_bcd;
          digit_err[i]     <= dec_err;
        end
      end
    end
  end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Reader side of the multiplexed 7-segment display interface: monitors the active-low anode and segment buses driven by the display scanner.
- Decodes each stably-displayed segment pattern back to its BCD digit and assembles one full frame of NUM_DIGITS digits.
- Used as an on-chip self-check of the digital clock display path and as a bench monitor.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (anode lines); range 2..8.
- STABLE_CYCLES, 8, consecutive identical samples required before a digit is captured; minimum 2.
- CNT_W, $clog2(STABLE_CYCLES+1), settle-counter width (derived, not overridden).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- an_n  input  NUM_DIGITS  anode enables, active-low; bit i low means digit i is displayed.
- seg_n  input  7  segments a..g on bits 6..0, active-low (0 = lit).
- digits  output  4*NUM_DIGITS  captured BCD values; digit i occupies [4i+3:4i].
- digit_err  output  NUM_DIGITS  bit i set when the last capture of digit i was an illegal pattern.
- frame_valid  output  1  one-cycle pulse when every digit has been captured since the last pulse.
- frame_err  output  1  OR of digit_err over the completed frame; meaningful only while frame_valid=1.
- multi_drive  output  1  one-cycle pulse per sampled cycle in which more than one an_n bit is low.

Behaviour:
- Inputs are registered once (an_q, seg_q); all logic below operates on the registered samples.
- Legal patterns: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Any other pattern decodes to 4'hF with the error bit set.
- FSM, three states:
  - BLANK: an_q all ones, or more than one bit low. Settle counter held at 0.
  - SETTLE: exactly one an_q bit low. Counter increments while {an_q, seg_q} equals the previous sample. Any change restarts the counter at 1, stays in SETTLE, and retargets the new index. When the counter reaches STABLE_CYCLES, capture and go to HELD.
  - HELD: no recapture while {an_q, seg_q} is unchanged. Any change goes to SETTLE with the counter at 1, or to BLANK if the anodes are not one-hot-low.
- Capture at index i, on the same edge:
  - digits[i] is written with the decoded value.
  - digit_err[i] is written with the error bit.
  - seen[i] is set.
- Latency: inputs held constant from edge k first appear in the sample at edge k+1. The capture is visible after edge k+STABLE_CYCLES.
- Frame completion: on the edge after seen becomes all ones:
  - frame_valid=1 for exactly one cycle.
  - frame_err is the OR of the digit_err bits captured in this frame.
  - seen is cleared.
  - A capture on that same edge sets its seen bit after the clear, so that capture counts toward the next frame.
- Revisiting a digit before the frame completes overwrites its digits/digit_err entry; seen is unchanged.
- multi_drive is a combinational decode of an_q: high for every cycle with two or more low bits. It does not affect seen or digits.
- Counter saturates at STABLE_CYCLES and never wraps.
- Reset (asynchronous, any time), clears:
  - digits, digit_err, seen, counter and the sample registers; an_q and seg_q reset to all ones.
  - frame_valid, frame_err and multi_drive to 0.
  - FSM returns to BLANK and any partial frame is discarded.
- Release of reset is synchronous to clk.

Decomposition:
- Package seg7_pkg holds:
  - SEG_W=7 and BCD_W=4.
  - The ten active-low pattern constants SEG_0..SEG_9.
  - BCD_INVALID=4'hF.
  - The FSM state enum {BLANK, SETTLE, HELD}.
- The display encoder shares the same constants.
- One combinational sub-module, seg7_decode (seg_n[6:0] -> bcd[3:0], err), instantiated once on seg_q.

Test Plan:
- Reset, then scan an_n=1110/1101/1011/0111 with patterns for 1,2,3,4, each held 20 cycles -> digits=16'h4321, digit_err=0, one frame_valid pulse with frame_err=0, then a second pulse for every further full scan.
- Hold digit 0 with seg_n=0010010 for exactly STABLE_CYCLES-1 cycles, then change -> no capture, digits[3:0] unchanged; hold for STABLE_CYCLES -> digits[3:0]=2, captured exactly STABLE_CYCLES edges after first application.
- Show illegal pattern 1111111 on digit 2 within a full scan -> digits[11:8]=4'hF, digit_err[2]=1, frame_err=1 on the frame_valid cycle.
- Drive an_n=1100 for 10 cycles mid-scan -> multi_drive high for 10 cycles, no capture, seen unchanged, and the scan completes the frame normally afterwards.
- Capture digits 0 and 1, assert rst_n=0 for 1 cycle, then scan only digits 2 and 3 -> no frame_valid; digits[7:0]=0 until digits 0 and 1 are shown again.
- Revisit digit 1 with 5 then 7 before digits 2 and 3 appear -> digits[7:4]=7 at frame_valid, single pulse.
